// File: rtl/wb_stage_if.sv
// Write-back stage bus: instruction fields from the memory stage, the LSU
// response, and the commit/forwarding/exception outputs.
interface wb_stage_if;
   logic        wb_valid;
   logic        rd_wr_en_wb;
   logic [4:0]  rd_wr_addr_wb;
   logic [31:0] rd_wr_data_wb;
   logic        lsu_en_wb;
   logic        wb_data_mux;
   logic [2:0]  lsu_dtype_wb;
   logic [31:0] lsu_addr_wb;
   logic [31:0] lsu_rdata;
   logic        lsu_valid;
   logic        lsu_err;
   logic        exc_taken_wb;
   logic [5:0]  exc_cause_wb;
   logic [31:0] exc_tval_wb;
   logic        ready_wb;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        forward_wb_en;
   logic [4:0]  forward_wb_addr;
   logic [31:0] forward_wb_wdata;
   logic        exc_req;
   logic [5:0]  exc_cause;
   logic [31:0] exc_tval;
   logic        retire;
   logic        spurious_rsp;

   modport master (
      output wb_valid, rd_wr_en_wb, rd_wr_addr_wb, rd_wr_data_wb, lsu_en_wb,
             wb_data_mux, lsu_dtype_wb, lsu_addr_wb, lsu_rdata, lsu_valid,
             lsu_err, exc_taken_wb, exc_cause_wb, exc_tval_wb,
      input  ready_wb, rf_we, rf_waddr, rf_wdata, forward_wb_en,
             forward_wb_addr, forward_wb_wdata, exc_req, exc_cause, exc_tval,
             retire, spurious_rsp
   );

   modport slave (
      input  wb_valid, rd_wr_en_wb, rd_wr_addr_wb, rd_wr_data_wb, lsu_en_wb,
             wb_data_mux, lsu_dtype_wb, lsu_addr_wb, lsu_rdata, lsu_valid,
             lsu_err, exc_taken_wb, exc_cause_wb, exc_tval_wb,
      output ready_wb, rf_we, rf_waddr, rf_wdata, forward_wb_en,
             forward_wb_addr, forward_wb_wdata, exc_req, exc_cause, exc_tval,
             retire, spurious_rsp
   );
endinterface

// File: rtl/wb_stage.sv
// Write-back stage: completes LSU responses, aligns load data, commits rd
// writes / forwarding and reports precise exceptions, one registered cycle late.
module wb_stage #(
   parameter int RSP_TIMEOUT = 64,
   parameter int CNT_W       = 7
) (
   input  logic      clk,
   input  logic      reset,
   wb_stage_if.slave wb
);

   typedef enum logic {IDLE, WAIT_RSP} state_e;

   typedef struct packed {
      logic        rd_en;
      logic [4:0]  rd;
      logic [31:0] data;
      logic        load;
      logic [2:0]  dtype;
      logic [31:0] addr;
   } op_t;

   typedef struct packed {
      logic        rf_we;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic        exc;
      logic [5:0]  cause;
      logic [31:0] tval;
      logic        retire;
      logic        spur;
   } commit_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RSP_TIMEOUT - 1);

   function automatic logic [31:0] align_load(logic [2:0] dtype, logic [1:0] off,
                                              logic [31:0] rdata);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      b = rdata[8*off +: 8];
      h = off[1] ? rdata[31:16] : rdata[15:0];
      case (dtype)
         3'd0:    r = {{24{b[7]}}, b};
         3'd1:    r = {{16{h[15]}}, h};
         3'd4:    r = {24'd0, b};
         3'd5:    r = {16'd0, h};
         default: r = rdata;
      endcase
      return r;
   endfunction

   // Errors and timeouts share this path: a timeout is an access fault.
   function automatic commit_t complete_op(op_t op, logic err, logic [31:0] rdata);
      commit_t c;
      c = '0;
      if (err) begin
         c.exc   = 1'b1;
         c.cause = op.load ? 6'd5 : 6'd7;
         c.tval  = op.addr;
      end else if (op.load) begin
         c.rf_we  = (op.rd != 5'd0);
         c.waddr  = op.rd;
         c.wdata  = align_load(op.dtype, op.addr[1:0], rdata);
         c.retire = 1'b1;
      end else begin
         c.rf_we  = op.rd_en && (op.rd != 5'd0);
         c.waddr  = op.rd;
         c.wdata  = op.data;
         c.retire = 1'b1;
      end
      return c;
   endfunction

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   op_t              cap_q, cap_d;
   commit_t          cmt_q, cmt_d;
   op_t              in_op, alu_op;
   logic             ready_c;

   always_comb begin
      in_op.rd_en = wb.rd_wr_en_wb;
      in_op.rd    = wb.rd_wr_addr_wb;
      in_op.data  = wb.rd_wr_data_wb;
      in_op.load  = wb.wb_data_mux;
      in_op.dtype = wb.lsu_dtype_wb;
      in_op.addr  = wb.lsu_addr_wb;
      alu_op      = in_op;
      alu_op.load = 1'b0;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cap_d   = cap_q;
      cmt_d   = '0;
      ready_c = 1'b1;
      case (state_q)
         IDLE: begin
            if (wb.wb_valid) begin
               cap_d = in_op;
               if (wb.exc_taken_wb) begin
                  cmt_d.exc   = 1'b1;
                  cmt_d.cause = wb.exc_cause_wb;
                  cmt_d.tval  = wb.exc_tval_wb;
               end else if (!wb.lsu_en_wb) begin
                  cmt_d = complete_op(alu_op, 1'b0, wb.lsu_rdata);
               end else if (wb.lsu_valid) begin
                  cmt_d = complete_op(in_op, wb.lsu_err, wb.lsu_rdata);
               end else begin
                  state_d = WAIT_RSP;
                  cnt_d   = '0;
                  ready_c = 1'b0;
               end
            end else if (wb.lsu_valid) begin
               cmt_d.spur = 1'b1;
            end
         end
         WAIT_RSP: begin
            ready_c = 1'b0;
            // A response arriving in the timeout cycle takes priority.
            if (wb.lsu_valid) begin
               cmt_d   = complete_op(cap_q, wb.lsu_err, wb.lsu_rdata);
               state_d = IDLE;
               ready_c = 1'b1;
            end else if (cnt_q == CNT_LAST) begin
               cmt_d   = complete_op(cap_q, 1'b1, wb.lsu_rdata);
               state_d = IDLE;
               ready_c = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         cap_q   <= '0;
         cmt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cap_q   <= cap_d;
         cmt_q   <= cmt_d;
      end
   end

   assign wb.ready_wb         = ready_c;
   assign wb.rf_we            = cmt_q.rf_we;
   assign wb.rf_waddr         = cmt_q.waddr;
   assign wb.rf_wdata         = cmt_q.wdata;
   assign wb.forward_wb_en    = cmt_q.rf_we;
   assign wb.forward_wb_addr  = cmt_q.waddr;
   assign wb.forward_wb_wdata = cmt_q.wdata;
   assign wb.exc_req          = cmt_q.exc;
   assign wb.exc_cause        = cmt_q.cause;
   assign wb.exc_tval         = cmt_q.tval;
   assign wb.retire           = cmt_q.retire;
   assign wb.spurious_rsp     = cmt_q.spur;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios with literal
// expectations, then randomized traffic against a transaction-level model.
module tb_wb_stage;
   localparam int T = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   wb_stage_if bus();

   wb_stage #(.RSP_TIMEOUT(T), .CNT_W(3)) dut (
      .clk   (clk),
      .reset (reset),
      .wb    (bus)
   );

   typedef struct {
      bit        wbv;
      bit        rd_en;
      bit [4:0]  rd;
      bit [31:0] data;
      bit        lsu_en;
      bit        load;
      bit [2:0]  dt;
      bit [31:0] addr;
      bit [31:0] rdata;
      bit        lv;
      bit        err;
      bit        exc;
      bit [5:0]  cause;
      bit [31:0] tval;
   } stim_t;

   typedef struct {
      bit        we;
      bit [4:0]  wa;
      bit [31:0] wd;
      bit        exc;
      bit [5:0]  cause;
      bit [31:0] tval;
      bit        ret;
      bit        spur;
   } cmt_t;

   int    n_pass = 0;
   int    n_tot  = 0;
   bit    cmp_en = 1'b0;

   // Model: at most one outstanding memory op and how long it has waited.
   bit    pend = 1'b0;
   stim_t pop;
   int    age = 0;
   cmt_t  exp_cur, exp_nxt;
   bit    exp_ready = 1'b1;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endfunction

   function automatic bit [31:0] ld_val(bit [2:0] dt, bit [31:0] a, bit [31:0] w);
      bit [31:0] s;
      longint    v;
      s = w >> (8 * a[1:0]);
      case (dt)
         3'd0: begin v = s & 32'hFF;   if (v >= 128)   v -= 256;   end
         3'd1: begin v = s & 32'hFFFF; if (v >= 32768) v -= 65536; end
         3'd4: v = s & 32'hFF;
         3'd5: v = s & 32'hFFFF;
         default: v = w;
      endcase
      return v[31:0];
   endfunction

   function automatic cmt_t resolve(stim_t op, bit err, bit [31:0] rdata);
      cmt_t c = '{default: 0};
      if (err) begin
         c.exc = 1; c.cause = op.load ? 6'd5 : 6'd7; c.tval = op.addr;
      end else if (op.load) begin
         c.we = (op.rd != 0); c.wa = op.rd; c.wd = ld_val(op.dt, op.addr, rdata); c.ret = 1;
      end else begin
         c.we = op.rd_en && (op.rd != 0); c.wa = op.rd; c.wd = op.data; c.ret = 1;
      end
      return c;
   endfunction

   task automatic model_step(stim_t s);
      cmt_t  c = '{default: 0};
      stim_t a;
      exp_ready = 1;
      if (!pend) begin
         if (s.wbv) begin
            if (s.exc) begin
               c.exc = 1; c.cause = s.cause; c.tval = s.tval;
            end else if (!s.lsu_en) begin
               a = s; a.load = 0; c = resolve(a, 0, s.rdata);
            end else if (s.lv) begin
               c = resolve(s, s.err, s.rdata);
            end else begin
               pend = 1; pop = s; age = 0; exp_ready = 0;
            end
         end else if (s.lv) begin
            c.spur = 1;
         end
      end else begin
         exp_ready = 0;
         if (s.lv) begin
            c = resolve(pop, s.err, s.rdata); pend = 0; exp_ready = 1;
         end else if (age == T - 1) begin
            c = resolve(pop, 1, s.rdata); pend = 0; exp_ready = 1;
         end else begin
            age++;
         end
      end
      exp_nxt = c;
   endtask

   task automatic drive(stim_t s);
      bus.wb_valid      = s.wbv;
      bus.rd_wr_en_wb   = s.rd_en;
      bus.rd_wr_addr_wb = s.rd;
      bus.rd_wr_data_wb = s.data;
      bus.lsu_en_wb     = s.lsu_en;
      bus.wb_data_mux   = s.load;
      bus.lsu_dtype_wb  = s.dt;
      bus.lsu_addr_wb   = s.addr;
      bus.lsu_rdata     = s.rdata;
      bus.lsu_valid     = s.lv;
      bus.lsu_err       = s.err;
      bus.exc_taken_wb  = s.exc;
      bus.exc_cause_wb  = s.cause;
      bus.exc_tval_wb   = s.tval;
   endtask

   task automatic step(stim_t s);
      @(posedge clk);
      #1;
      reset   = 1'b0;
      exp_cur = exp_nxt;
      drive(s);
      model_step(s);
      #1;
   endtask

   task automatic do_reset();
      stim_t idle = '{default: 0};
      @(posedge clk);
      #1;
      reset     = 1'b1;
      drive(idle);
      pend      = 0;
      exp_cur   = '{default: 0};
      exp_nxt   = '{default: 0};
      exp_ready = 1;
      #1;
   endtask

   function automatic stim_t mem(bit load, bit [2:0] dt, bit [31:0] addr, bit [4:0] rd);
      stim_t s = '{default: 0};
      s.wbv = 1; s.lsu_en = 1; s.load = load; s.dt = dt; s.addr = addr;
      s.rd = rd; s.rd_en = load;
      return s;
   endfunction

   function automatic stim_t rand_stim();
      stim_t s = '{default: 0};
      bit [2:0] dts [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      s.rdata = $urandom;
      s.err   = ($urandom_range(0, 4) == 0);
      if (pend) begin
         s.lv = ($urandom_range(0, 2) == 0);
      end else if ($urandom_range(0, 2) != 0) begin
         s.wbv    = 1;
         s.rd_en  = $urandom_range(0, 1);
         s.rd     = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
         s.data   = $urandom;
         s.lsu_en = $urandom_range(0, 1);
         s.load   = $urandom_range(0, 1);
         s.dt     = dts[$urandom_range(0, 4)];
         s.addr   = $urandom;
         if (s.dt == 3'd1 || s.dt == 3'd5) s.addr[0] = 1'b0;
         if (s.dt == 3'd2) s.addr[1:0] = 2'b00;
         s.exc    = ($urandom_range(0, 7) == 0);
         s.cause  = 6'($urandom_range(0, 63));
         s.tval   = $urandom;
         s.lv     = s.lsu_en ? bit'($urandom_range(0, 1)) : ($urandom_range(0, 5) == 0);
         if (s.exc && s.lsu_en) s.lv = 0;
      end else begin
         s.lv = ($urandom_range(0, 5) == 0);
      end
      return s;
   endfunction

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("ready_wb", bus.ready_wb, exp_ready);
         chk("rf_we", bus.rf_we, exp_cur.we);
         chk("forward_wb_en", bus.forward_wb_en, exp_cur.we);
         chk("retire", bus.retire, exp_cur.ret);
         chk("exc_req", bus.exc_req, exp_cur.exc);
         chk("spurious_rsp", bus.spurious_rsp, exp_cur.spur);
         if (exp_cur.we) begin
            chk("rf_waddr", bus.rf_waddr, exp_cur.wa);
            chk("rf_wdata", bus.rf_wdata, exp_cur.wd);
            chk("forward_wb_addr", bus.forward_wb_addr, exp_cur.wa);
            chk("forward_wb_wdata", bus.forward_wb_wdata, exp_cur.wd);
         end
         if (exp_cur.exc) begin
            chk("exc_cause", bus.exc_cause, exp_cur.cause);
            chk("exc_tval", bus.exc_tval, exp_cur.tval);
         end
      end
   end

   initial begin
      stim_t s;
      stim_t idle;
      int    stall;
      idle = '{default: 0};
      drive(idle);
      exp_cur = '{default: 0};
      exp_nxt = '{default: 0};
      repeat (2) @(posedge clk);
      #2;
      cmp_en = 1'b1;
      chk("reset ready_wb", bus.ready_wb, 1);
      chk("reset rf_we", bus.rf_we, 0);
      chk("reset exc_req", bus.exc_req, 0);
      chk("reset retire", bus.retire, 0);

      // ALU write
      s = idle; s.wbv = 1; s.rd_en = 1; s.rd = 5; s.data = 32'h1234;
      step(s);
      chk("alu ready_wb", bus.ready_wb, 1);
      step(idle);
      chk("alu rf_we", bus.rf_we, 1);
      chk("alu rf_waddr", bus.rf_waddr, 5);
      chk("alu rf_wdata", bus.rf_wdata, 32'h1234);
      chk("alu retire", bus.retire, 1);

      // LB, response three cycles late
      s = mem(1, 3'd0, 32'h0000_0103, 7);
      step(s);
      stall = (bus.ready_wb == 0);
      step(idle); stall += (bus.ready_wb == 0);
      step(idle); stall += (bus.ready_wb == 0);
      s = idle; s.lv = 1; s.rdata = 32'h80FF_0000;
      step(s);
      chk("lb stall cycles", stall, 3);
      chk("lb ready at rsp", bus.ready_wb, 1);
      step(idle);
      chk("lb rf_wdata", bus.rf_wdata, 32'hFFFF_FF80);
      chk("lb rf_we", bus.rf_we, 1);

      // LBU on the same data
      s = mem(1, 3'd4, 32'h0000_0103, 7);
      step(s);
      step(idle);
      s = idle; s.lv = 1; s.rdata = 32'h80FF_0000;
      step(s);
      step(idle);
      chk("lbu rf_wdata", bus.rf_wdata, 32'h0000_0080);

      // LH, same-cycle response
      s = mem(1, 3'd1, 32'h0000_0202, 9); s.lv = 1; s.rdata = 32'h8001_7FFF;
      step(s);
      chk("lh ready_wb", bus.ready_wb, 1);
      step(idle);
      chk("lh rf_wdata", bus.rf_wdata, 32'hFFFF_8001);

      // Store with bus error
      s = mem(0, 3'd2, 32'h0000_2000, 4); s.lv = 1; s.err = 1;
      step(s);
      step(idle);
      chk("st err exc_req", bus.exc_req, 1);
      chk("st err cause", bus.exc_cause, 7);
      chk("st err tval", bus.exc_tval, 32'h2000);
      chk("st err rf_we", bus.rf_we, 0);
      chk("st err retire", bus.retire, 0);

      // Load with no response -> timeout, then a stray response
      s = mem(1, 3'd2, 32'h0000_0300, 8);
      step(s);
      repeat (T - 1) step(idle);
      chk("to ready before", bus.ready_wb, 0);
      step(idle);
      chk("to ready at timeout", bus.ready_wb, 1);
      step(idle);
      chk("to exc_req", bus.exc_req, 1);
      chk("to cause", bus.exc_cause, 5);
      chk("to tval", bus.exc_tval, 32'h300);
      s = idle; s.lv = 1;
      step(s);
      step(idle);
      chk("stray spurious_rsp", bus.spurious_rsp, 1);
      chk("stray rf_we", bus.rf_we, 0);

      // Pipeline-carried exception on a memory op
      s = mem(1, 3'd2, 32'h0000_0500, 3); s.exc = 1; s.cause = 6'd2; s.tval = 32'hDEAD;
      step(s);
      chk("pexc ready_wb", bus.ready_wb, 1);
      step(idle);
      chk("pexc exc_req", bus.exc_req, 1);
      chk("pexc cause", bus.exc_cause, 2);
      chk("pexc tval", bus.exc_tval, 32'hDEAD);
      chk("pexc rf_we", bus.rf_we, 0);

      // Write to x0
      s = idle; s.wbv = 1; s.rd_en = 1; s.rd = 0; s.data = 32'h55;
      step(s);
      step(idle);
      chk("x0 rf_we", bus.rf_we, 0);
      chk("x0 forward_wb_en", bus.forward_wb_en, 0);
      chk("x0 retire", bus.retire, 1);

      // Reset while waiting discards the pending op
      s = mem(1, 3'd2, 32'h0000_0400, 10);
      step(s);
      step(idle);
      do_reset();
      chk("midrst ready_wb", bus.ready_wb, 1);
      chk("midrst rf_we", bus.rf_we, 0);
      s = idle; s.lv = 1;
      step(s);
      step(idle);
      chk("midrst spurious_rsp", bus.spurious_rsp, 1);
      chk("midrst rf_we after", bus.rf_we, 0);

      repeat (3000) step(rand_stim());
      step(idle);
      step(idle);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Final pipeline stage. Consumes the write-back register set produced by the memory stage.
- Completes outstanding load/store responses from the LSU, and aligns and sign-extends load data.
- Commits register-file writes, provides the WB-stage forwarding path, and reports precise exceptions (pipeline-carried or bus-response) to the controller.
- Stalls the pipeline through ready_wb while a memory response is pending; a timeout counter guards against lost responses.

Parameters:
RSP_TIMEOUT, 64, cycles spent in WAIT_RSP before a missing response is converted into an access-fault exception (must be >= 2)
CNT_W, 7, width of the timeout counter (must satisfy 2**CNT_W > RSP_TIMEOUT)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
wb_valid  input  1  one-cycle pulse: a new instruction is presented on the *_wb inputs
rd_wr_en_wb  input  1  instruction writes rd
rd_wr_addr_wb  input  5  rd index
rd_wr_data_wb  input  32  ALU/CSR result for rd
lsu_en_wb  input  1  instruction is a load or store
wb_data_mux  input  1  1 = load (rd takes memory data), 0 = store
lsu_dtype_wb  input  3  0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU
lsu_addr_wb  input  32  effective memory address
lsu_rdata  input  32  raw word-aligned read data from LSU
lsu_valid  input  1  LSU response strobe
lsu_err  input  1  response error, qualified by lsu_valid
exc_taken_wb  input  1  instruction carries an earlier exception
exc_cause_wb  input  6  its cause
exc_tval_wb  input  32  its tval
ready_wb  output  1  stage can accept; 0 stalls the memory stage
rf_we  output  1  register-file write enable
rf_waddr  output  5  register-file write index
rf_wdata  output  32  register-file write data
forward_wb_en  output  1  forwarding valid
forward_wb_addr  output  5  forwarding index
forward_wb_wdata  output  32  forwarding data
exc_req  output  1  one-cycle exception commit pulse to controller
exc_cause  output  6  exception cause
exc_tval  output  32  exception tval
retire  output  1  one-cycle pulse per instruction retired without exception
spurious_rsp  output  1  one-cycle pulse: lsu_valid received while nothing pending

Behaviour:
- Reset: state=IDLE, counter=0, captured fields=0.
  - All outputs 0 except ready_wb, which is 1.
- FSM states:
  - IDLE -> WAIT_RSP: wb_valid & lsu_en_wb & ~exc_taken_wb & ~lsu_valid.
  - WAIT_RSP -> IDLE: lsu_valid, or counter == RSP_TIMEOUT-1.
- Capture: on wb_valid in IDLE, latch rd_wr_en, rd addr, load flag, dtype, addr[31:0] into internal regs. A response in WAIT_RSP uses the latched values.
- Completion event C, evaluated in the cycle it occurs:
  - (a) wb_valid with exc_taken_wb=1: no memory wait; lsu_valid that cycle is ignored.
  - (b) wb_valid with lsu_en_wb=0.
  - (c) wb_valid with lsu_en_wb=1 and lsu_valid=1 in the same cycle.
  - (d) lsu_valid in WAIT_RSP.
  - (e) timeout in WAIT_RSP.
- All commit outputs are registered; they appear in cycle C+1 for exactly one cycle.
- ready_wb (combinational):
  - IDLE: 1, except 0 when wb_valid & lsu_en_wb & ~exc_taken_wb & ~lsu_valid.
  - WAIT_RSP: 0, except 1 in the completion cycle (d or e).
- Commit results, by completion type:
  - (a): exc_req=1, cause/tval passed through; rf_we=0; retire=0.
  - (b), or a store completing without error: rf_we=rd_wr_en & (rd!=0), rf_wdata=rd_wr_data; retire=1.
  - Load without error: rf_we=(rd!=0), rf_wdata=aligned load data; retire=1.
  - lsu_err=1 or timeout: exc_req=1, exc_cause = 5 for a load or 7 for a store, exc_tval = latched address; rf_we=0; retire=0.
- Load alignment (off = addr[1:0]):
  - Byte select: lsu_rdata[8*off+7 : 8*off].
  - Half select: off[1] ? [31:16] : [15:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
  - Misaligned addresses are excluded upstream and not checked here.
- Writes to x0 are suppressed: rf_we=0 and forward_wb_en=0.
- Forwarding mirrors the registered commit: forward_wb_en=rf_we, addr/wdata equal rf_waddr/rf_wdata.
- Timeout counter:
  - Cleared on entry to WAIT_RSP; increments each WAIT_RSP cycle without lsu_valid.
  - lsu_valid and timeout in the same cycle: the response wins, timeout is not reported.
- lsu_valid in IDLE without a wb_valid memory op: spurious_rsp=1 next cycle, otherwise dropped.
- wb_valid while in WAIT_RSP is a protocol violation; it is ignored (verification asserts it never occurs).
- Reset asserted mid-WAIT_RSP: immediate return to IDLE, no commit, pending response discarded.

Test Plan:
1. ALU op: wb_valid, rd=5, data 0x1234, lsu_en=0 -> next cycle rf_we=1, waddr=5, wdata=0x1234, retire=1; ready_wb stays 1.
2. LB, addr 0x...03, lsu_valid 3 cycles late with rdata 0x80FF_0000 -> ready_wb=0 for 3 cycles, then rf_wdata=0xFFFF_FF80; LBU on the same data -> 0x0000_0080.
3. LH, addr offset 2, same-cycle lsu_valid, rdata 0x8001_7FFF -> no stall, rf_wdata=0xFFFF_8001.
4. Store with lsu_err=1 at addr 0x2000 -> exc_req=1, cause=7, tval=0x2000, rf_we=0, retire=0.
5. Load with no response, RSP_TIMEOUT=4 -> after 4 WAIT_RSP cycles exc_req=1, cause=5; a later stray lsu_valid -> spurious_rsp=1, no rf write.
6. exc_taken_wb=1, cause 2, with lsu_en=1 and rd=3 -> exc_req, cause=2, no stall, rf_we=0. Separately: write to rd=0 -> rf_we=0, forward_wb_en=0, retire=1.
